pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the fetch stage: holds the architectural fetch PC in a register and selects the next PC from trap vector, branch redirect, return-address prediction or sequential PC+4. It replaces the combinational next-PC mux in front of instruction fetch and adds reset/boot sequencing, a halt state, a fetch handshake and an optional return-address stack (RAS).

## Interface
- XLEN, 32, PC width in bits (≥ 8)
- RESET_PC, 32'h0000_0000, first fetch address after reset (XLEN bits, low 2 bits zero)
- RAS_DEPTH, 4, RAS entries (power of two, ≥ 2); used only with RAS compiled in
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- if_ready  input  1  fetch accepts the current PC this cycle
- redirect_valid  input  1  branch/jump resolved taken in EX
- redirect_pc  input  XLEN  branch/jump target
- trap_valid  input  1  exception/interrupt entry
- trap_pc  input  XLEN  trap vector
- halt_req  input  1  stop fetching after the current PC is accepted
- ras_push  input  1  call predecoded in the accepted fetch; push pc4
- ras_pop  input  1  return predecoded in the accepted fetch; predict from RAS top
- pc  output  XLEN  current fetch PC
- pc4  output  XLEN  pc + 4
- pc_valid  output  1  pc is a valid fetch request

## Operation
- States: BOOT, RUN, HALT. Reset → BOOT, pc = RESET_PC, pc_valid = 0, RAS empty (count 0, pointer 0).
- BOOT: one cycle, pc_valid = 0, then RUN unconditionally (trap/redirect in BOOT are applied instead of going to RUN with RESET_PC).
- RUN: pc_valid = 1. Next-PC priority, highest first:
  1. trap_valid → pc ← trap_pc, RAS cleared, state RUN.
  2. redirect_valid → pc ← redirect_pc, RAS unchanged.
  3. no fire (if_ready = 0) → pc held.
  4. fire (pc_valid & if_ready) with halt_req → pc ← pc4, state HALT.
  5. fire with ras_pop and RAS non-empty → pc ← RAS top.
  6. fire → pc ← pc4.
- trap/redirect are honoured regardless of if_ready and in every state; both exit HALT to RUN.
- HALT: pc_valid = 0, pc held; only trap or redirect leave it.
- Target low 2 bits (trap_pc, redirect_pc) forced to 0 on load.
- Arithmetic: pc4 = pc + 4 modulo 2^XLEN; 2^XLEN−4 wraps to 0 with no flag.
- ras_push/ras_pop act only on a fire cycle without trap/redirect; otherwise ignored.

## Timing
- pc, pc_valid, state, RAS are registers; pc4 and next-PC combinational from them.
- Redirect latency: redirect_valid in cycle N → pc = redirect_pc with pc_valid = 1 in cycle N+1.
- First valid fetch: cycle 2 after rst_n deasserts (BOOT occupies cycle 1).
- pc stable while pc_valid & !if_ready (valid/ready hold rule); pc_valid never drops without fire, trap, redirect or reset.
- RAS push and pop in one fire cycle: pop read first (prediction = old top), then top overwritten with pc4; count unchanged.
- Push when full: circular overwrite of oldest entry, count saturates at RAS_DEPTH.
- Pop when empty: no prediction, pc ← pc4, count stays 0.
- rst_n low mid-operation: immediate return to BOOT/RESET_PC, RAS emptied.

## Configuration
- PC_GEN_RAS_EN defined: RAS of RAS_DEPTH × XLEN entries built, ras_push/ras_pop behave as above.
- Undefined: no RAS storage; ras_push/ras_pop ports remain but are ignored; priority item 5 removed, fire → pc4.

## Structure
- Shared package pc_pkg: state enum (BOOT, RUN, HALT), default RESET_PC, PC alignment mask constant.
- One sub-module pc_ras (push/pop/clear, top, empty), instantiated only under PC_GEN_RAS_EN.

## Test plan
- Reset, RESET_PC = 0x100, if_ready = 1 → cycle 1 pc_valid = 0; then pc = 0x100, 0x104, 0x108.
- if_ready = 0 for 3 cycles at pc = 0x104 → pc holds 0x104, pc_valid = 1; redirect_valid, redirect_pc = 0x203 during stall → next pc = 0x200.
- trap_valid (trap_pc = 0x80) and redirect_valid (0x400) same cycle → pc = 0x80, RAS empty.
- halt_req on fire at pc = 0x10 → pc = 0x14, pc_valid = 0 held; redirect to 0x40 → pc = 0x40, pc_valid = 1.
- RAS on, push at pc 0x20 (pushes 0x24), later pop at 0x50 → pc = 0x24; pop on empty at 0x60 → pc = 0x64; 5 pushes with RAS_DEPTH = 4 then 4 pops → pushes 2–5 returned newest first.
- pc = 0xFFFF_FFFC, fire → pc = 0x0000_0000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // Bits of a loaded target that are forced to zero (word-aligned fetch).
  localparam logic [1:0]  PC_ALIGN_MASK    = 2'b11;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: redirect/trap/halt/RAS hints in, fetch PC out.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            if_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            halt_req;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic            pc_valid;

  modport master (
    input  if_ready, redirect_valid, redirect_pc, trap_valid, trap_pc,
           halt_req, ras_push, ras_pop,
    output pc, pc4, pc_valid
  );

  modport slave (
    output if_ready, redirect_valid, redirect_pc, trap_valid, trap_pc,
           halt_req, ras_push, ras_pop,
    input  pc, pc4, pc_valid
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// push+pop together replaces the top, clear empties it.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   tptr;
  logic [CW-1:0]   cnt;
  logic            do_pop;

  assign tptr   = wptr - PW'(1);
  assign empty  = (cnt == '0);
  assign top    = mem[tptr];
  assign do_pop = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      wptr <= '0;
      cnt  <= '0;
    end else if (push && do_pop) begin
      wptr <= wptr;
      cnt  <= cnt;
    end else if (push) begin
      wptr <= wptr + PW'(1);
      if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
    end else if (do_pop) begin
      wptr <= tptr;
      cnt  <= cnt - CW'(1);
    end
  end

  // Prediction reads the old top combinationally, so overwriting it here is safe.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[do_pop ? tptr : wptr] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT sequencing and trap > redirect > hold >
// halt > RAS > pc+4 next-PC selection. Optional RAS under PC_GEN_RAS_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(PC_RESET_DEFAULT),
  parameter int              RAS_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_gen_if.master  bus
);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(PC_ALIGN_MASK);

  pc_state_e       state, nxt_state;
  logic [XLEN-1:0] pc_q, nxt_pc, pc4, ras_top;
  logic            fire, ras_empty, ras_clr, ras_psh, ras_pp;

  assign pc4          = pc_q + XLEN'(4);
  assign bus.pc       = pc_q;
  assign bus.pc4      = pc4;
  assign bus.pc_valid = (state == RUN);
  assign fire         = bus.pc_valid & bus.if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
    end else begin
      state <= nxt_state;
      pc_q  <= nxt_pc;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_pc    = pc_q;
    ras_clr   = 1'b0;
    ras_psh   = 1'b0;
    ras_pp    = 1'b0;
    if (bus.trap_valid) begin
      nxt_pc    = bus.trap_pc & ALIGN;
      nxt_state = RUN;
      ras_clr   = 1'b1;
    end else if (bus.redirect_valid) begin
      nxt_pc    = bus.redirect_pc & ALIGN;
      nxt_state = RUN;
    end else begin
      case (state)
        BOOT: nxt_state = RUN;
        RUN: begin
          if (fire) begin
            // RAS bookkeeping follows every accepted fetch, even the halting one.
            ras_psh = bus.ras_push;
            ras_pp  = bus.ras_pop;
            if (bus.halt_req) begin
              nxt_pc    = pc4;
              nxt_state = HALT;
            end else if (bus.ras_pop && !ras_empty) begin
              nxt_pc = ras_top;
            end else begin
              nxt_pc = pc4;
            end
          end
        end
        HALT: nxt_state = HALT;
        default: nxt_state = BOOT;
      endcase
    end
  end

`ifdef PC_GEN_RAS_EN
  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ras_clr),
    .push      (ras_psh),
    .pop       (ras_pp),
    .push_data (pc4),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras;
  assign unused_ras = ^{ras_clr, ras_psh, ras_pp};
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
`endif

endmodule
